pair_packer: RTL and testbench

- Downstream consumer of the two-input merge stage. Takes its single D_WIDTH valid/ready output stream and packs each two consecutive words into one 2*D_WIDTH word.
- Packed words are buffered in a 2**A_WIDTH-deep output FIFO.
- A flush input forces out a lone pending word as a marked odd entry, so the end of a stream is never stranded.

---
 rtl/pair_packer_pkg.sv | 10 +
 rtl/pair_packer_fifo.sv | 58 +++++
 rtl/pair_packer.sv | 106 ++++++++++
 tb/tb_pair_packer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pair_packer_pkg.sv
// Shared types for the pair packer: FSM state encoding.
// Imported by the packer top and its output FIFO.
package pair_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pair_state_t;

endpackage

// File: rtl/pair_packer_fifo.sv
// Synchronous FIFO with registered write and count-based full/empty.
// Read data is the current head entry (show-ahead).
module sync_fifo
    import pair_pkg::*;
#(
    parameter int WIDTH   = 13,
    parameter int A_WIDTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               rd_en,
    output logic [WIDTH-1:0]   rd_data,
    output logic               empty,
    output logic               full,
    output logic [A_WIDTH:0]   count
);

    localparam int DEPTH = 1 << A_WIDTH;
    localparam logic [A_WIDTH:0] DEPTH_C = (A_WIDTH+1)'(DEPTH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [A_WIDTH-1:0] wr_ptr;
    logic [A_WIDTH-1:0] rd_ptr;

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally; occupancy lives only in count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + A_WIDTH'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + A_WIDTH'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + (A_WIDTH+1)'(1);
                2'b01:   count <= count - (A_WIDTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pair_packer.sv
// Packs consecutive upstream words into double-width FIFO entries.
// Flush pushes out a lone pending word as an odd entry.
module pair_packer
    import pair_pkg::*;
#(
    parameter int D_WIDTH = 6,
    parameter int A_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [D_WIDTH-1:0]   up_data,
    input  logic                 up_valid,
    output logic                 up_ready,
    input  logic                 flush,
    output logic [2*D_WIDTH-1:0] down_data,
    output logic                 down_odd,
    output logic                 down_valid,
    input  logic                 down_ready,
    output logic [A_WIDTH:0]     count
);

    typedef struct packed {
        logic               odd;
        logic [D_WIDTH-1:0] hi;
        logic [D_WIDTH-1:0] lo;
    } entry_t;

    localparam int E_WIDTH = $bits(entry_t);

    pair_state_t        state;
    pair_state_t        state_nxt;
    logic [D_WIDTH-1:0] hold_lo;
    entry_t             wr_entry;
    entry_t             rd_entry;
    logic               wr_en;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic               space;

    assign down_valid = ~fifo_empty;
    assign pop        = down_valid & down_ready;
    assign space      = ~fifo_full | pop;
    // A full FIFO is never empty, so down_ready alone implies a pop.
    assign up_ready   = (state == EMPTY) | ~fifo_full | down_ready;
    assign push       = up_valid & up_ready;

    assign down_data  = down_valid ? {rd_entry.hi, rd_entry.lo} : '0;
    assign down_odd   = down_valid & rd_entry.odd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            hold_lo <= '0;
        end else begin
            state <= state_nxt;
            if (state == EMPTY && push) begin
                hold_lo <= up_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_entry  = '0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt = HALF;
                end
            end
            HALF: begin
                if (push) begin
                    wr_en       = 1'b1;
                    wr_entry.hi = up_data;
                    wr_entry.lo = hold_lo;
                    state_nxt   = EMPTY;
                end else if (flush && space) begin
                    wr_en        = 1'b1;
                    wr_entry.odd = 1'b1;
                    wr_entry.lo  = hold_lo;
                    state_nxt    = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    sync_fifo #(
        .WIDTH   (E_WIDTH),
        .A_WIDTH (A_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (rd_entry),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (count)
    );

endmodule

// File: tb/tb_pair_packer.sv
// Directed and randomised self-checking bench for pair_packer.
// Expected packed words are computed from the words the bench drives.
module tb_pair_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  up_data;
    logic        up_valid;
    logic        up_ready;
    logic        flush;
    logic [11:0] down_data;
    logic        down_odd;
    logic        down_valid;
    logic        down_ready;
    logic [2:0]  count;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    pair_packer #(.D_WIDTH(6), .A_WIDTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_data    (up_data),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .flush      (flush),
        .down_data  (down_data),
        .down_odd   (down_odd),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .count      (count)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0]  first;
    logic        have_first;
    logic [11:0] exp_q[$];
    logic        push;
    logic        pop;
    int          sent;
    int          got;
    int          cyc;

    initial begin
        rst        = 1'b1;
        up_valid   = 1'b0;
        up_data    = '0;
        flush      = 1'b0;
        down_ready = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("rst_valid", down_valid, 0);
        check("rst_count", count, 0);
        check("rst_ready", up_ready, 1);
        check("rst_data", down_data, 0);
        check("rst_odd", down_odd, 0);

        // Basic pair
        down_ready = 1'b1;
        up_valid   = 1'b1;
        up_data    = 6'h01;
        tick();
        up_data = 6'h02;
        tick();
        up_valid = 1'b0;
        check("pair_valid", down_valid, 1);
        check("pair_data", down_data, 12'h081);
        check("pair_odd", down_odd, 0);
        check("pair_count", count, 1);
        tick();
        check("pair_pop_count", count, 0);

        // Flush of a lone word
        up_valid = 1'b1;
        up_data  = 6'h15;
        tick();
        up_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_data", down_data, 12'h015);
        check("flush_odd", down_odd, 1);
        check("flush_count", count, 1);
        tick();
        check("flush_pop", count, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("flush_empty_cnt", count, 0);
        check("flush_empty_vld", down_valid, 0);

        // Fill with down_ready low
        down_ready = 1'b0;
        up_valid   = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            up_data = 6'(i);
            tick();
        end
        check("fill_count", count, 4);
        up_data = 6'd9;
        #1;
        check("fill_ready9", up_ready, 1);
        tick();
        up_data = 6'd10;
        #1;
        check("fill_ready10", up_ready, 0);
        tick();
        check("fill_hold_cnt", count, 4);
        check("fill_head", down_data, 12'h081);
        down_ready = 1'b1;
        #1;
        check("fill_ready_pop", up_ready, 1);
        tick();
        up_valid = 1'b0;
        check("fill_pp_count", count, 4);
        check("fill_d1", down_data, 12'h103);
        tick();
        check("fill_d2", down_data, 12'h185);
        tick();
        check("fill_d3", down_data, 12'h207);
        tick();
        check("fill_d4", down_data, 12'h289);
        check("fill_d4_odd", down_odd, 0);
        tick();
        check("fill_drained", count, 0);

        // Push beats flush in HALF
        down_ready = 1'b0;
        up_valid   = 1'b1;
        up_data    = 6'h03;
        tick();
        up_data = 6'h2A;
        flush   = 1'b1;
        tick();
        up_valid = 1'b0;
        tick();
        flush = 1'b0;
        check("prio_count", count, 1);
        check("prio_data", down_data, 12'hA83);
        check("prio_odd", down_odd, 0);
        down_ready = 1'b1;
        tick();
        check("prio_drain", count, 0);

        // Reset mid-operation
        down_ready = 1'b0;
        up_valid   = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            up_data = 6'(i);
            tick();
        end
        up_valid = 1'b0;
        check("rst2_pre_count", count, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_valid", down_valid, 0);
        check("rst2_count", count, 0);
        check("rst2_ready", up_ready, 1);
        down_ready = 1'b1;
        up_valid   = 1'b1;
        up_data    = 6'h11;
        tick();
        up_data = 6'h22;
        tick();
        up_valid = 1'b0;
        check("rst2_data", down_data, 12'h891);
        check("rst2_odd", down_odd, 0);
        tick();
        check("rst2_drain", count, 0);

        // Random valid/ready traffic
        have_first = 1'b0;
        sent       = 0;
        got        = 0;
        cyc        = 0;
        while ((sent < 1000 || got < 500) && cyc < 20000) begin
            if (!up_valid && sent < 1000 && $urandom_range(0, 1) == 1) begin
                up_valid = 1'b1;
                up_data  = 6'($urandom_range(0, 63));
            end
            down_ready = 1'($urandom_range(0, 1));
            #3;
            push = up_valid & up_ready;
            pop  = down_valid & down_ready;
            if (pop) begin
                if (exp_q.size() == 0) begin
                    check("rand_extra", {down_odd, down_data}, 32'hFFFF);
                end else begin
                    check("rand_pair", {down_odd, down_data},
                          {1'b0, exp_q.pop_front()});
                end
                got++;
            end
            if (push) begin
                if (have_first) begin
                    exp_q.push_back({up_data, first});
                    have_first = 1'b0;
                end else begin
                    first      = up_data;
                    have_first = 1'b1;
                end
                sent++;
            end
            tick();
            cyc++;
            if (push) up_valid = 1'b0;
        end
        up_valid = 1'b0;
        check("rand_timeout", (cyc < 20000), 1);
        check("rand_left", exp_q.size(), 0);
        check("rand_count", count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
